// File: rtl/ipv4_tcp_header_parser_pkg.sv
// Shared types and byte offsets for the IPv4/TCP header parser.
// Imported by the parser FSM and the record register bank.
package ipv4_tcp_header_parser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IP_HDR,
    TCP_HDR,
    DRAIN
  } state_e;

  typedef enum logic [3:0] {
    CAP_NONE,
    CAP_VIHL,
    CAP_TOS,
    CAP_LEN_H,
    CAP_LEN_L,
    CAP_ID_H,
    CAP_ID_L,
    CAP_FRAG_H,
    CAP_FRAG_L,
    CAP_DOFF,
    CAP_FLAGS,
    CAP_WIN_H,
    CAP_WIN_L
  } cap_e;

  localparam logic [5:0] IP_TOS    = 6'd1;
  localparam logic [5:0] IP_TOTLEN = 6'd2;
  localparam logic [5:0] IP_ID     = 6'd4;
  localparam logic [5:0] IP_FRAG   = 6'd6;
  localparam logic [5:0] IP_PROTO  = 6'd9;
  localparam logic [4:0] TCP_DOFF  = 5'd12;
  localparam logic [4:0] TCP_FLAGS = 5'd13;
  localparam logic [4:0] TCP_WIN   = 5'd14;
  localparam logic [4:0] TCP_LAST  = 5'd15;

  localparam logic [3:0] IPV4_VERSION = 4'd4;
  localparam logic [7:0] PROTO_TCP    = 8'd6;
  localparam logic [3:0] MIN_IHL      = 4'd5;

  function automatic cap_e ip_cap(input logic [5:0] idx);
    case (idx)
      IP_TOS:          ip_cap = CAP_TOS;
      IP_TOTLEN:       ip_cap = CAP_LEN_H;
      IP_TOTLEN + 6'd1: ip_cap = CAP_LEN_L;
      IP_ID:           ip_cap = CAP_ID_H;
      IP_ID + 6'd1:    ip_cap = CAP_ID_L;
      IP_FRAG:         ip_cap = CAP_FRAG_H;
      IP_FRAG + 6'd1:  ip_cap = CAP_FRAG_L;
      default:         ip_cap = CAP_NONE;
    endcase
  endfunction

  function automatic cap_e tcp_cap(input logic [4:0] idx);
    case (idx)
      TCP_DOFF:       tcp_cap = CAP_DOFF;
      TCP_FLAGS:      tcp_cap = CAP_FLAGS;
      TCP_WIN:        tcp_cap = CAP_WIN_H;
      TCP_WIN + 5'd1: tcp_cap = CAP_WIN_L;
      default:        tcp_cap = CAP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ipv4_tcp_header_parser_if.sv
// Byte-stream input and header-record output bundle.
// slave = parser side, master = source/consumer side.
interface ipv4_tcp_header_parser_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] l3_iph_tot_len;
  logic [3:0]  l3_iph_ihl;
  logic [7:0]  l3_iph_tos;
  logic [12:0] l3_iph_frag_off;
  logic [15:0] l3_iph_id;
  logic        l3_iph_df;
  logic [15:0] l4_tcph_window;
  logic        l4_tcph_syn;
  logic        l4_tcph_fin;
  logic        l4_tcph_rst;
  logic        l4_tcph_ack;
  logic [3:0]  l4_tcph_doff;
  logic        hdr_valid;
  logic        hdr_err;
  logic        hdr_ready;

  modport slave (
    input  in_data, in_valid, in_last, hdr_ready,
    output in_ready, l3_iph_tot_len, l3_iph_ihl,
    output l3_iph_tos, l3_iph_frag_off, l3_iph_id,
    output l3_iph_df, l4_tcph_window, l4_tcph_syn,
    output l4_tcph_fin, l4_tcph_rst, l4_tcph_ack,
    output l4_tcph_doff, hdr_valid, hdr_err
  );

  modport master (
    output in_data, in_valid, in_last, hdr_ready,
    input  in_ready, l3_iph_tot_len, l3_iph_ihl,
    input  l3_iph_tos, l3_iph_frag_off, l3_iph_id,
    input  l3_iph_df, l4_tcph_window, l4_tcph_syn,
    input  l4_tcph_fin, l4_tcph_rst, l4_tcph_ack,
    input  l4_tcph_doff, hdr_valid, hdr_err
  );
endinterface

// File: rtl/ipv4_tcp_header_parser_hdr_record_reg.sv
// Output field bank, record valid/ready holding
// and saturating error-record counter.
module ipv4_tcp_header_parser_hdr_record_reg
  import ipv4_tcp_header_parser_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cap_e             cap_i,
  input  logic [7:0]       data_i,
  input  logic             done_i,
  input  logic             done_err_i,
  input  logic             hdr_ready_i,
  output logic [15:0]      tot_len_o,
  output logic [3:0]       ihl_o,
  output logic [7:0]       tos_o,
  output logic [12:0]      frag_off_o,
  output logic [15:0]      id_o,
  output logic             df_o,
  output logic [15:0]      window_o,
  output logic             syn_o,
  output logic             fin_o,
  output logic             rst_o,
  output logic             ack_o,
  output logic [3:0]       doff_o,
  output logic             hdr_valid_o,
  output logic             hdr_err_o,
  output logic [CNT_W-1:0] err_count_o
);

  logic [15:0]      tot_len_q, id_q, window_q;
  logic [12:0]      frag_off_q;
  logic [7:0]       tos_q;
  logic [3:0]       ihl_q, doff_q;
  logic             df_q, syn_q, fin_q, rst_q, ack_q;
  logic             valid_q, err_q;
  logic [CNT_W-1:0] cnt_q;

  // Field capture, record hold and error counting; a new
  // completion takes priority over the clearing handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tot_len_q  <= '0;
      id_q       <= '0;
      window_q   <= '0;
      frag_off_q <= '0;
      tos_q      <= '0;
      ihl_q      <= '0;
      doff_q     <= '0;
      df_q       <= 1'b0;
      syn_q      <= 1'b0;
      fin_q      <= 1'b0;
      rst_q      <= 1'b0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (cap_i)
        CAP_VIHL: begin
          tot_len_q  <= '0;
          id_q       <= '0;
          window_q   <= '0;
          frag_off_q <= '0;
          tos_q      <= '0;
          doff_q     <= '0;
          df_q       <= 1'b0;
          syn_q      <= 1'b0;
          fin_q      <= 1'b0;
          rst_q      <= 1'b0;
          ack_q      <= 1'b0;
          err_q      <= 1'b0;
          ihl_q      <= data_i[3:0];
        end
        CAP_TOS:    tos_q <= data_i;
        CAP_LEN_H:  tot_len_q[15:8] <= data_i;
        CAP_LEN_L:  tot_len_q[7:0] <= data_i;
        CAP_ID_H:   id_q[15:8] <= data_i;
        CAP_ID_L:   id_q[7:0] <= data_i;
        CAP_FRAG_H: begin
          df_q              <= data_i[6];
          frag_off_q[12:8]  <= data_i[4:0];
        end
        CAP_FRAG_L: frag_off_q[7:0] <= data_i;
        CAP_DOFF:   doff_q <= data_i[7:4];
        CAP_FLAGS: begin
          fin_q <= data_i[0];
          syn_q <= data_i[1];
          rst_q <= data_i[2];
          ack_q <= data_i[4];
        end
        CAP_WIN_H:  window_q[15:8] <= data_i;
        CAP_WIN_L:  window_q[7:0] <= data_i;
        default: ;
      endcase
      if (valid_q && hdr_ready_i) begin
        valid_q <= 1'b0;
        if (err_q && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
      end
      if (done_i) begin
        valid_q <= 1'b1;
        err_q   <= done_err_i;
      end
    end
  end

  assign tot_len_o   = tot_len_q;
  assign ihl_o       = ihl_q;
  assign tos_o       = tos_q;
  assign frag_off_o  = frag_off_q;
  assign id_o        = id_q;
  assign df_o        = df_q;
  assign window_o    = window_q;
  assign syn_o       = syn_q;
  assign fin_o       = fin_q;
  assign rst_o       = rst_q;
  assign ack_o       = ack_q;
  assign doff_o      = doff_q;
  assign hdr_valid_o = valid_q;
  assign hdr_err_o   = err_q;
  assign err_count_o = cnt_q;

endmodule

// File: rtl/ipv4_tcp_header_parser.sv
// IPv4/TCP header parser: byte-stream FSM with index
// counters feeding the header record register bank.
module ipv4_tcp_header_parser
  import ipv4_tcp_header_parser_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ipv4_tcp_header_parser_if.slave bus,
  output logic [CNT_W-1:0]        err_count
);

  state_e     state_q, state_d;
  logic [5:0] ip_idx_q, ip_idx_d;
  logic [4:0] tcp_idx_q, tcp_idx_d;
  logic [5:0] ip_last;
  logic [3:0] ihl;
  logic       acc, done, done_err, stall;
  cap_e       cap;

  assign stall = (state_q == IDLE) && bus.hdr_valid && !bus.hdr_ready;
  assign bus.in_ready = rst_n && !stall;
  assign acc = bus.in_valid && bus.in_ready;
  assign ip_last = {ihl, 2'b00} - 6'd1;

  // State and byte-index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ip_idx_q  <= '0;
      tcp_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ip_idx_q  <= ip_idx_d;
      tcp_idx_q <= tcp_idx_d;
    end
  end

  // Next state, capture select and record completion per byte.
  always_comb begin
    state_d   = state_q;
    ip_idx_d  = ip_idx_q;
    tcp_idx_d = tcp_idx_q;
    cap       = CAP_NONE;
    done      = 1'b0;
    done_err  = 1'b0;
    if (acc) begin
      unique case (state_q)
        IDLE: begin
          cap      = CAP_VIHL;
          ip_idx_d = 6'd1;
          if (bus.in_data[7:4] != IPV4_VERSION ||
              bus.in_data[3:0] < MIN_IHL) begin
            done     = 1'b1;
            done_err = 1'b1;
            state_d  = bus.in_last ? IDLE : DRAIN;
          end else if (bus.in_last) begin
            done     = 1'b1;
            done_err = 1'b1;
          end else begin
            state_d = IP_HDR;
          end
        end
        IP_HDR: begin
          cap      = ip_cap(ip_idx_q);
          ip_idx_d = ip_idx_q + 6'd1;
          if (ip_idx_q == IP_PROTO && bus.in_data != PROTO_TCP) begin
            done     = 1'b1;
            done_err = 1'b1;
            state_d  = bus.in_last ? IDLE : DRAIN;
          end else if (bus.in_last) begin
            done     = 1'b1;
            done_err = 1'b1;
            state_d  = IDLE;
          end else if (ip_idx_q == ip_last) begin
            state_d   = TCP_HDR;
            tcp_idx_d = '0;
          end
        end
        TCP_HDR: begin
          cap       = tcp_cap(tcp_idx_q);
          tcp_idx_d = tcp_idx_q + 5'd1;
          if (tcp_idx_q == TCP_LAST) begin
            done    = 1'b1;
            state_d = bus.in_last ? IDLE : DRAIN;
          end else if (bus.in_last) begin
            done     = 1'b1;
            done_err = 1'b1;
            state_d  = IDLE;
          end
        end
        DRAIN: begin
          if (bus.in_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  ipv4_tcp_header_parser_hdr_record_reg #(
    .CNT_W(CNT_W)
  ) u_rec (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_i       (cap),
    .data_i      (bus.in_data),
    .done_i      (done),
    .done_err_i  (done_err),
    .hdr_ready_i (bus.hdr_ready),
    .tot_len_o   (bus.l3_iph_tot_len),
    .ihl_o       (ihl),
    .tos_o       (bus.l3_iph_tos),
    .frag_off_o  (bus.l3_iph_frag_off),
    .id_o        (bus.l3_iph_id),
    .df_o        (bus.l3_iph_df),
    .window_o    (bus.l4_tcph_window),
    .syn_o       (bus.l4_tcph_syn),
    .fin_o       (bus.l4_tcph_fin),
    .rst_o       (bus.l4_tcph_rst),
    .ack_o       (bus.l4_tcph_ack),
    .doff_o      (bus.l4_tcph_doff),
    .hdr_valid_o (bus.hdr_valid),
    .hdr_err_o   (bus.hdr_err),
    .err_count_o (err_count)
  );

  assign bus.l3_iph_ihl = ihl;

endmodule

// File: tb/tb_ipv4_tcp_header_parser.sv
// Directed bench for the IPv4/TCP header parser.
// Packets are built in a byte array and streamed in.
module tb_ipv4_tcp_header_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] err_count;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          hs_cnt = 0;
  int          hs_cyc = 0;
  int          mark_cyc = -1;
  bit          stall0;
  logic [7:0]  pkt [0:255];
  int          plen;
  logic [15:0] ids [$];

  ipv4_tcp_header_parser_if bus ();

  ipv4_tcp_header_parser #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst_n && bus.hdr_valid && bus.hdr_ready) begin
      hs_cnt <= hs_cnt + 1;
      hs_cyc <= cyc;
      ids.push_back(bus.l3_iph_id);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [7:0] vihl, input logic [7:0] tos,
                       input logic [15:0] tlen, input logic [15:0] id,
                       input logic [7:0] b6, input logic [7:0] b7,
                       input logic [7:0] proto, input logic [7:0] doffb,
                       input logic [7:0] flg, input logic [15:0] win,
                       input int pay);
    int ih;
    ih = int'(vihl[3:0]) * 4;
    plen = ih + 20 + pay;
    for (int i = 0; i < plen; i++) pkt[i] = 8'(i);
    pkt[0] = vihl;
    pkt[1] = tos;
    pkt[2] = tlen[15:8];
    pkt[3] = tlen[7:0];
    pkt[4] = id[15:8];
    pkt[5] = id[7:0];
    pkt[6] = b6;
    pkt[7] = b7;
    pkt[9] = proto;
    pkt[ih + 12] = doffb;
    pkt[ih + 13] = flg;
    pkt[ih + 14] = win[15:8];
    pkt[ih + 15] = win[7:0];
  endtask

  task automatic send(input int n, input bit last_en, input int mark);
    int g;
    bit tmo;
    tmo = 1'b0;
    stall0 = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_data  = pkt[i];
      bus.in_valid = 1'b1;
      bus.in_last  = last_en && (i == n - 1);
      g = 0;
      while (!bus.in_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (g >= 100) tmo = 1'b1;
      if (i == 0 && g > 0) stall0 = 1'b1;
      if (i == mark) mark_cyc = cyc;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("send_no_timeout", 32'(tmo), 32'd0);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.hdr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_hdr_valid", 32'(bus.hdr_valid), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_tot_len", 32'(bus.l3_iph_tot_len), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // minimal SYN packet
    build(8'h45, 8'h00, 16'd40, 16'h1234, 8'h40, 8'h00, 8'd6,
          8'h50, 8'h02, 16'hFAF0, 0);
    send(plen, 1'b1, 35);
    settle();
    chk("syn_hs_count", 32'(hs_cnt), 32'd1);
    chk("syn_latency", 32'(hs_cyc), 32'(mark_cyc + 1));
    chk("syn_tot_len", 32'(bus.l3_iph_tot_len), 32'd40);
    chk("syn_ihl", 32'(bus.l3_iph_ihl), 32'd5);
    chk("syn_id", 32'(bus.l3_iph_id), 32'h1234);
    chk("syn_df", 32'(bus.l3_iph_df), 32'd1);
    chk("syn_frag", 32'(bus.l3_iph_frag_off), 32'd0);
    chk("syn_flags", {28'd0, bus.l4_tcph_syn, bus.l4_tcph_fin,
        bus.l4_tcph_rst, bus.l4_tcph_ack}, 32'h8);
    chk("syn_doff", 32'(bus.l4_tcph_doff), 32'd5);
    chk("syn_window", 32'(bus.l4_tcph_window), 32'hFAF0);
    chk("syn_err", 32'(bus.hdr_err), 32'd0);
    chk("syn_valid_clr", 32'(bus.hdr_valid), 32'd0);

    // IP options, FIN+ACK, 100-byte payload drained
    build(8'h47, 8'h10, 16'd148, 16'hBEEF, 8'h21, 8'h34, 8'd6,
          8'h50, 8'h11, 16'h0100, 100);
    send(plen, 1'b1, -1);
    settle();
    chk("opt_hs_count", 32'(hs_cnt), 32'd2);
    chk("opt_ihl", 32'(bus.l3_iph_ihl), 32'd7);
    chk("opt_tos", 32'(bus.l3_iph_tos), 32'h10);
    chk("opt_tot_len", 32'(bus.l3_iph_tot_len), 32'd148);
    chk("opt_df", 32'(bus.l3_iph_df), 32'd0);
    chk("opt_frag", 32'(bus.l3_iph_frag_off), 32'h0134);
    chk("opt_flags", {28'd0, bus.l4_tcph_syn, bus.l4_tcph_fin,
        bus.l4_tcph_rst, bus.l4_tcph_ack}, 32'h5);
    chk("opt_window", 32'(bus.l4_tcph_window), 32'h0100);
    chk("opt_err", 32'(bus.hdr_err), 32'd0);

    // UDP: error after byte 9, rest drained
    build(8'h45, 8'h00, 16'd40, 16'h0777, 8'h00, 8'h00, 8'd17,
          8'h50, 8'h12, 16'hAAAA, 0);
    send(plen, 1'b1, 9);
    settle();
    chk("udp_hs_count", 32'(hs_cnt), 32'd3);
    chk("udp_latency", 32'(hs_cyc), 32'(mark_cyc + 1));
    chk("udp_err", 32'(bus.hdr_err), 32'd1);
    chk("udp_err_count", 32'(err_count), 32'd1);
    chk("udp_id", 32'(bus.l3_iph_id), 32'h0777);
    chk("udp_window", 32'(bus.l4_tcph_window), 32'd0);
    chk("udp_doff", 32'(bus.l4_tcph_doff), 32'd0);
    chk("udp_flags", {28'd0, bus.l4_tcph_syn, bus.l4_tcph_fin,
        bus.l4_tcph_rst, bus.l4_tcph_ack}, 32'h0);

    // truncated at byte 25, then a clean packet
    build(8'h45, 8'h00, 16'd40, 16'h1234, 8'h40, 8'h00, 8'd6,
          8'h50, 8'h02, 16'hFAF0, 0);
    send(26, 1'b1, -1);
    settle();
    chk("trunc_hs_count", 32'(hs_cnt), 32'd4);
    chk("trunc_err", 32'(bus.hdr_err), 32'd1);
    chk("trunc_err_count", 32'(err_count), 32'd2);
    chk("trunc_window", 32'(bus.l4_tcph_window), 32'd0);
    send(plen, 1'b1, -1);
    settle();
    chk("post_trunc_err", 32'(bus.hdr_err), 32'd0);
    chk("post_trunc_window", 32'(bus.l4_tcph_window), 32'hFAF0);
    chk("post_trunc_syn", 32'(bus.l4_tcph_syn), 32'd1);

    // back-to-back with consumer stalled for 10 cycles
    bus.hdr_ready = 1'b0;
    send(plen, 1'b1, -1);
    repeat (2) @(negedge clk);
    chk("b2b_pending", 32'(bus.hdr_valid), 32'd1);
    chk("b2b_stall", 32'(bus.in_ready), 32'd0);
    build(8'h45, 8'h00, 16'd40, 16'h5678, 8'h00, 8'h00, 8'd6,
          8'h50, 8'h10, 16'h1111, 0);
    fork
      send(plen, 1'b1, -1);
      begin
        repeat (10) @(posedge clk);
        #1 bus.hdr_ready = 1'b1;
      end
    join
    settle();
    chk("b2b_stall0", 32'(stall0), 32'd1);
    chk("b2b_hs_count", 32'(hs_cnt), 32'd7);
    chk("b2b_first_id", 32'(ids[ids.size() - 2]), 32'h1234);
    chk("b2b_second_id", 32'(ids[ids.size() - 1]), 32'h5678);
    chk("b2b_ack", 32'(bus.l4_tcph_ack), 32'd1);
    chk("b2b_window", 32'(bus.l4_tcph_window), 32'h1111);
    chk("b2b_err", 32'(bus.hdr_err), 32'd0);

    // reset while in TCP_HDR, then a fresh packet
    build(8'h47, 8'h10, 16'd148, 16'hBEEF, 8'h21, 8'h34, 8'd6,
          8'h50, 8'h11, 16'h0100, 100);
    send(40, 1'b0, -1);
    chk("pre_rst_err_count", 32'(err_count), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_valid", 32'(bus.hdr_valid), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_tot_len", 32'(bus.l3_iph_tot_len), 32'd0);
    rst_n = 1'b1;
    send(plen, 1'b1, -1);
    settle();
    chk("after_rst_id", 32'(bus.l3_iph_id), 32'hBEEF);
    chk("after_rst_frag", 32'(bus.l3_iph_frag_off), 32'h0134);
    chk("after_rst_window", 32'(bus.l4_tcph_window), 32'h0100);
    chk("after_rst_err", 32'(bus.hdr_err), 32'd0);
    chk("after_rst_err_count", 32'(err_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
